// File: rtl/spi_pkg.sv
// Shared types and bit-order helpers for the oversampling SPI slave.
package spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {IDLE, ACTIVE} spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic msb;
  } spi_mode_t;

  // MSB-first shifts left (new bit at 0); LSB-first shifts right (new bit at 7).
  function automatic logic [BYTE_W-1:0] rx_shift(input logic [BYTE_W-1:0] sr,
                                                 input logic bit_in,
                                                 input logic msb);
    if (msb) return {sr[BYTE_W-2:0], bit_in};
    else     return {bit_in, sr[BYTE_W-1:1]};
  endfunction

  function automatic logic tx_bit(input logic [BYTE_W-1:0] sr, input logic msb);
    return msb ? sr[BYTE_W-1] : sr[0];
  endfunction

  function automatic logic [BYTE_W-1:0] tx_next(input logic [BYTE_W-1:0] sr,
                                                input logic msb);
    if (msb) return {sr[BYTE_W-2:0], 1'b0};
    else     return {1'b0, sr[BYTE_W-1:1]};
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a history flop for edge detection.
module spi_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign q    = sync_p1;
  assign rise = sync_p1 & ~hist_p2;
  assign fall = ~sync_p1 & hist_p2;

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI slave, all four CPOL/CPHA modes, oversampled in the clk_i domain.
module spi_slave
  import spi_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ena_i,
  input  logic              tx_ena,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              MSB,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              CS,
  input  logic              SCK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              done,
  output logic [BYTE_W-1:0] rx_data
);

  localparam logic [2:0] LAST_BIT = 3'(BYTE_W - 1);

  logic cs_q, cs_rise, cs_fall;
  logic sck_q, sck_rise, sck_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync u_sync_cs   (.clk_i(clk_i), .rst_i(rst_i), .d(CS),   .q(cs_q),   .rise(cs_rise),   .fall(cs_fall));
  spi_sync u_sync_sck  (.clk_i(clk_i), .rst_i(rst_i), .d(SCK),  .q(sck_q),  .rise(sck_rise),  .fall(sck_fall));
  spi_sync u_sync_mosi (.clk_i(clk_i), .rst_i(rst_i), .d(MOSI), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_sync;
  assign unused_sync = cs_q | sck_q | mosi_rise | mosi_fall;

  spi_state_t        state;
  spi_mode_t         mode;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] rx_sr;
  logic [BYTE_W-1:0] tx_sr;

  logic              lead_edge, trail_edge, sample_edge, shift_edge;
  logic [BYTE_W-1:0] tx_load;
  logic [BYTE_W-1:0] rx_next;

  assign lead_edge   = mode.cpol ? sck_fall : sck_rise;
  assign trail_edge  = mode.cpol ? sck_rise : sck_fall;
  assign sample_edge = mode.cpha ? trail_edge : lead_edge;
  assign shift_edge  = mode.cpha ? lead_edge  : trail_edge;
  assign tx_load     = tx_ena ? tx_data : '0;
  assign rx_next     = rx_shift(rx_sr, mosi_q, mode.msb);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      mode    <= '0;
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      MISO    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_rise && ena_i) begin
            state   <= ACTIVE;
            mode    <= '{cpol: CPOL, cpha: CPHA, msb: MSB};
            bit_cnt <= '0;
            rx_sr   <= '0;
            // CPHA=0 needs the first bit on the wire before the first sample edge.
            if (CPHA) begin
              tx_sr <= tx_load;
            end else begin
              MISO  <= tx_bit(tx_load, MSB);
              tx_sr <= tx_next(tx_load, MSB);
            end
          end
        end
        ACTIVE: begin
          // CS deselect takes priority over any coincident SCK edge.
          if (cs_fall || !ena_i) begin
            state   <= IDLE;
            bit_cnt <= '0;
            MISO    <= 1'b0;
          end else if (sample_edge) begin
            rx_sr   <= rx_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              rx_data  <= rx_next;
              done     <= 1'b1;
              // Next byte's first bit goes out on the following shift edge.
              tx_sr    <= tx_load;
              mode.msb <= MSB;
            end
          end else if (shift_edge) begin
            MISO  <= tx_bit(tx_sr, mode.msb);
            tx_sr <= tx_next(tx_sr, mode.msb);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed and randomized bench for spi_slave with a bit-sequence level master/reference model.
module tb_spi_slave;

  logic       clk_i = 1'b0;
  logic       rst_i, ena_i, tx_ena, MSB, CPOL, CPHA, CS, SCK, MOSI;
  logic [7:0] tx_data;
  logic       MISO, done;
  logic [7:0] rx_data;

  spi_slave dut (
    .clk_i(clk_i), .rst_i(rst_i), .ena_i(ena_i), .tx_ena(tx_ena), .tx_data(tx_data),
    .MSB(MSB), .CPOL(CPOL), .CPHA(CPHA), .CS(CS), .SCK(SCK), .MOSI(MOSI),
    .MISO(MISO), .done(done), .rx_data(rx_data)
  );

  always #5 clk_i = ~clk_i;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] done_q[$];
  int         done_wide = 0;
  logic       done_d = 1'b0;
  logic [7:0] last_rx = 8'h00;

  always @(posedge clk_i) begin
    #1;
    if (done === 1'b1) done_q.push_back(rx_data);
    if (done === 1'b1 && done_d === 1'b1) done_wide++;
    done_d = done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit i of the result is the i-th bit on the wire for a byte sent in the given order.
  function automatic logic [7:0] wire_seq(input logic [7:0] b, input logic msb);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = msb ? b[7-i] : b[i];
    return s;
  endfunction

  task automatic half();
    repeat (6) @(negedge clk_i);
  endtask

  task automatic cs_begin(input logic cpol, input logic cpha, input logic msb,
                          input logic txe, input logic [7:0] txd);
    CPOL = cpol; CPHA = cpha; MSB = msb; tx_ena = txe; tx_data = txd;
    SCK = cpol; MOSI = 1'b0;
    repeat (4) @(negedge clk_i);
    CS = 1'b1;
    half();
  endtask

  task automatic cs_end();
    CS = 1'b0;
    repeat (6) @(negedge clk_i);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input logic msb,
                           output logic [7:0] miso_seq);
    logic [7:0] seq;
    seq = wire_seq(b, msb);
    miso_seq = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!CPHA) begin
        MOSI = seq[i];
        half();
        miso_seq[i] = MISO;
        SCK = ~CPOL;
        half();
        SCK = CPOL;
      end else begin
        SCK = ~CPOL;
        MOSI = seq[i];
        half();
        miso_seq[i] = MISO;
        SCK = CPOL;
        half();
      end
    end
  endtask

  task automatic xfer(input string tag, input logic cpol, input logic cpha, input logic msb,
                      input logic txe, input logic [7:0] txd, input logic [7:0] rxb);
    logic [7:0] ms;
    done_q.delete();
    cs_begin(cpol, cpha, msb, txe, txd);
    send_bits(rxb, 8, msb, ms);
    cs_end();
    check({tag, "_done_cnt"}, done_q.size(), 1);
    if (done_q.size() > 0) check({tag, "_done_data"}, done_q[0], rxb);
    check({tag, "_rx_data"}, rx_data, rxb);
    check({tag, "_miso"}, ms, wire_seq(txe ? txd : 8'h00, msb));
    check({tag, "_done_width"}, done_wide, 0);
    last_rx = rxb;
  endtask

  initial begin
    logic [7:0] ms0, ms1, b0, b1, t0, t1;
    logic       m0, m1, pol, pha;

    rst_i = 1'b0; ena_i = 1'b1; tx_ena = 1'b0; tx_data = 8'h00; MSB = 1'b1;
    CPOL = 1'b0; CPHA = 1'b0; CS = 1'b0; SCK = 1'b0; MOSI = 1'b0;
    repeat (5) @(negedge clk_i);
    check("rst_done", done, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_miso", MISO, 0);
    rst_i = 1'b1;
    repeat (4) @(negedge clk_i);

    xfer("mode0_msb", 1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom), 8'hA5);
    xfer("mode3_lsb", 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 8'h96);
    xfer("txoff_mode1", 1'b0, 1'b1, 1'($urandom), 1'b0, 8'hFF, 8'($urandom));

    // Partial byte: no done, rx_data keeps the previous byte.
    done_q.delete();
    cs_begin(1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
    send_bits(8'h3F, 5, 1'b1, ms0);
    cs_end();
    check("partial_done_cnt", done_q.size(), 0);
    check("partial_rx_hold", rx_data, last_rx);
    check("partial_miso_idle", MISO, 0);
    xfer("after_partial", 1'b1, 1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom));

    // Back-to-back bytes under one CS; second byte re-captures tx_data and MSB.
    for (int k = 0; k < 2; k++) begin
      pol = 1'($urandom); pha = 1'($urandom);
      m0 = 1'($urandom); m1 = 1'($urandom);
      b0 = 8'($urandom); b1 = 8'($urandom); t0 = 8'($urandom); t1 = 8'($urandom);
      done_q.delete();
      cs_begin(pol, pha, m0, 1'b1, t0);
      tx_data = t1; MSB = m1;
      send_bits(b0, 8, m0, ms0);
      send_bits(b1, 8, m1, ms1);
      cs_end();
      check("b2b_done_cnt", done_q.size(), 2);
      if (done_q.size() == 2) begin
        check("b2b_byte0", done_q[0], b0);
        check("b2b_byte1", done_q[1], b1);
      end
      check("b2b_miso0", ms0, wire_seq(t0, m0));
      check("b2b_miso1", ms1, wire_seq(t1, m1));
      check("b2b_done_width", done_wide, 0);
      last_rx = b1;
    end

    for (int k = 0; k < 6; k++)
      xfer("random", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom));

    // Disabled block ignores a whole transfer.
    done_q.delete();
    ena_i = 1'b0;
    cs_begin(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
    send_bits(8'hC3, 8, 1'b1, ms0);
    cs_end();
    check("disabled_done_cnt", done_q.size(), 0);
    check("disabled_rx_hold", rx_data, last_rx);
    check("disabled_miso", ms0, 8'h00);
    ena_i = 1'b1;

    // Reset in the middle of a byte.
    done_q.delete();
    cs_begin(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
    send_bits(8'hF0, 4, 1'b1, ms0);
    rst_i = 1'b0;
    @(negedge clk_i);
    CS = 1'b0;
    repeat (5) @(negedge clk_i);
    check("midrst_done", done, 0);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_miso", MISO, 0);
    check("midrst_done_cnt", done_q.size(), 0);
    rst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    xfer("after_reset", 1'($urandom), 1'($urandom), 1'($urandom), 1'b1,
         8'($urandom), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
